// File: rtl/stopwatch_pkg.sv
// Shared constants and types for the stopwatch serial interface.
// Holds the board clock and line rate, the derived bit period and the
// receiver state encoding used by uart_rx_byte.
package stopwatch_pkg;

    // Board oscillator frequency and host serial line rate.
    localparam int CLK_HZ = 100_000_000;
    localparam int BAUD   = 115200;

    // Whole clk cycles per serial bit, truncated.
    // 100 MHz / 115200 gives 868, which keeps the bit timing error well under 1 %.
    function automatic int clksPerBit(input int clkHz, input int baud);
        return clkHz / baud;
    endfunction

    // Receiver states.
    // BREAK covers a line that is still low after a bad stop bit, so a
    // held-low line can report only one framing error.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rxState_e;

endpackage

// File: rtl/sync_bit.sv
// N-flop synchroniser for a single asynchronous input.
// Every stage resets to 1, the idle level of the serial line and of the
// active-low inputs it guards, so reset never looks like an input edge.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    // Shift the raw input through the chain; only the last stage is used downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver for the board RsRx line.
// The serial line is synchronised, then framed by a single state machine
// driven by a baud counter. Each good byte goes into a one-entry
// valid/ready holding register. A stop bit sampled low gives a one-cycle
// frame_err. A good byte that arrives while the holding register is full
// is dropped and sets the sticky overrun flag.
module uart_rx_byte
    import stopwatch_pkg::*;
#(
    parameter int CLKS_PER_BIT = clksPerBit(CLK_HZ, BAUD),
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RsRx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] MID_CNT  = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

    rxState_e      r_state;
    logic [CW-1:0] r_baudCnt;
    logic [2:0]    r_bitIdx;
    logic [7:0]    r_shift;
    logic          r_deliver;
    logic          r_frameErr;
    logic [7:0]    r_data;
    logic          r_valid;
    logic          r_overrun;

    logic          w_rxs;
    logic          w_midBit;
    logic          w_bitEnd;
    logic          w_handshake;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_rxSync (
        .clk (clk),
        .rst (rst),
        .i_d (RsRx),
        .o_q (w_rxs)
    );

    assign w_midBit    = (r_baudCnt == MID_CNT);
    assign w_bitEnd    = (r_baudCnt == LAST_CNT);
    assign w_handshake = r_valid && rx_ready;

    // Frame the synchronised line.
    // START waits half a bit so that every later sample, taken a whole bit
    // period apart, lands near the centre of a data bit.
    // A good stop bit raises r_deliver for one cycle, and the holding
    // register takes the byte on the following edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_baudCnt  <= '0;
            r_bitIdx   <= '0;
            r_shift    <= '0;
            r_deliver  <= 1'b0;
            r_frameErr <= 1'b0;
        end else begin
            r_deliver  <= 1'b0;
            r_frameErr <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_baudCnt <= '0;
                    if (!w_rxs) begin
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_midBit) begin
                        r_baudCnt <= '0;
                        r_bitIdx  <= '0;
                        r_state   <= w_rxs ? IDLE : DATA;
                    end else begin
                        r_baudCnt <= r_baudCnt + 1'b1;
                    end
                end
                DATA: begin
                    if (w_bitEnd) begin
                        r_baudCnt          <= '0;
                        r_shift[r_bitIdx]  <= w_rxs;
                        if (r_bitIdx == 3'd7) begin
                            r_state <= STOP;
                        end else begin
                            r_bitIdx <= r_bitIdx + 3'd1;
                        end
                    end else begin
                        r_baudCnt <= r_baudCnt + 1'b1;
                    end
                end
                STOP: begin
                    if (w_bitEnd) begin
                        r_baudCnt <= '0;
                        if (w_rxs) begin
                            r_deliver <= 1'b1;
                            r_state   <= IDLE;
                        end else begin
                            r_frameErr <= 1'b1;
                            r_state    <= BREAK;
                        end
                    end else begin
                        r_baudCnt <= r_baudCnt + 1'b1;
                    end
                end
                BREAK: begin
                    if (!w_rxs) begin
                        r_baudCnt <= '0;
                    end else if (w_bitEnd) begin
                        r_baudCnt <= '0;
                        r_state   <= IDLE;
                    end else begin
                        r_baudCnt <= r_baudCnt + 1'b1;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_baudCnt <= '0;
                end
            endcase
        end
    end

    // One-entry holding register.
    // A byte delivered in the same cycle as a handshake replaces the byte
    // being taken, so rx_valid stays high.
    // overrun is set only when a byte is dropped, and it clears on the next
    // accepted handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data    <= 8'h00;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (r_deliver && (!r_valid || w_handshake)) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (w_handshake) begin
                r_valid <= 1'b0;
            end

            if (r_deliver && r_valid && !rx_ready) begin
                r_overrun <= 1'b1;
            end else if (w_handshake) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign rx_data   = r_data;
    assign rx_valid  = r_valid;
    assign frame_err = r_frameErr;
    assign overrun   = r_overrun;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Self-checking bench for uart_rx_byte with a 16-cycle bit period.
// The stimulus side drives whole serial frames and records what the
// receiver should present.
// A free-running monitor checks each byte as it is handed over, and
// counts frame_err pulses.
module tb_uart_rx_byte;

    localparam int CPB  = 16;
    localparam int SYNC = 2;
    localparam int LATENCY_NOM = SYNC + (CPB - 1) / 2 + 9 * CPB + 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       RsRx;
    logic       rxReady;
    logic [7:0] rxData;
    logic       rxValid;
    logic       frameErr;
    logic       overrun;
    logic       busy;

    int checks = 0;
    int passes = 0;

    // Expected results from the reference model.
    logic [7:0] expQ[$];
    bit         modelFull  = 1'b0;
    bit         expOverrun = 1'b0;
    int         expErrs    = 0;

    // Activity seen by the monitor.
    int errPulses   = 0;
    int errCycles   = 0;
    int validCycles = 0;
    bit prevErr     = 1'b0;

    always #5ns clk = ~clk;

    uart_rx_byte #(
        .CLKS_PER_BIT (CPB),
        .SYNC_STAGES  (SYNC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .RsRx      (RsRx),
        .rx_data   (rxData),
        .rx_valid  (rxValid),
        .rx_ready  (rxReady),
        .frame_err (frameErr),
        .overrun   (overrun),
        .busy      (busy)
    );

    // Count one comparison, and report it if it does not match.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Wait n edges, then step 1 ns past the edge so that drives and samples stay clear of it.
    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1ns;
    endtask

    task automatic driveBit(input logic v);
        RsRx = v;
        waitCycles(CPB);
    endtask

    // Reference model of what the receiver should produce for one frame.
    // A good stop bit yields the byte, unless the holding slot is already
    // full. In that case the byte is lost and overrun is expected.
    // A bad stop bit yields a framing error.
    task automatic modelFrame(input logic [7:0] data, input logic stopBit);
        if (!stopBit) begin
            expErrs++;
        end else if (!modelFull) begin
            expQ.push_back(data);
            if (!rxReady) modelFull = 1'b1;
        end else begin
            expOverrun = 1'b1;
        end
    endtask

    // Send one 8N1 frame, LSB first.
    // The model is updated before the stop bit is driven, because the byte
    // is handed over before the stop bit has finished on the wire.
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
        driveBit(1'b0);
        for (int i = 0; i < 8; i++) driveBit(data[i]);
        modelFrame(data, stopBit);
        driveBit(stopBit);
    endtask

    // Monitor: check every byte that is handed over, and count frame_err activity.
    always @(negedge clk) begin
        if (rxValid) validCycles++;
        if (rxValid && rxReady) begin
            if (expQ.size() == 0) begin
                checks++;
                $display("[TB] FAIL unexpected byte: got %0h, expected no byte", rxData);
            end else begin
                checkOutput("rx_data", 32'(rxData), 32'(expQ.pop_front()));
            end
        end
        if (frameErr) begin
            errCycles++;
            if (!prevErr) errPulses++;
        end
        prevErr = frameErr;
    end

    initial begin
        int latency;
        int snapValid;
        int busyHigh;
        int gap;
        logic [7:0] b;
        bit bad;

        // Reset with the line idle, then check that the idle line causes no activity.
        rst = 1'b1;
        RsRx = 1'b1;
        rxReady = 1'b1;
        waitCycles(10);
        rst = 1'b0;
        waitCycles(1);
        checkOutput("reset rx_valid", 32'(rxValid), 32'd0);
        checkOutput("reset rx_data", 32'(rxData), 32'h00);
        checkOutput("reset frame_err", 32'(frameErr), 32'd0);
        checkOutput("reset overrun", 32'(overrun), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        busyHigh = 0;
        for (int i = 0; i < 500; i++) begin
            waitCycles(1);
            if (busy || rxValid) busyHigh++;
        end
        checkOutput("idle activity", 32'(busyHigh), 32'd0);

        // Single frame with the consumer ready.
        // The latency count includes the edge that first registers the line
        // change, so the window is the nominal value minus 1 to plus 2.
        snapValid = validCycles;
        latency = 0;
        fork
            applyStimulus(8'hA5, 1'b1);
            begin
                while (!rxValid && latency < 400) begin
                    waitCycles(1);
                    latency++;
                end
            end
        join
        waitCycles(2 * CPB);
        checkOutput("latency window", 32'((latency >= LATENCY_NOM - 1) && (latency <= LATENCY_NOM + 2)), 32'd1);
        checkOutput("A5 valid cycles", 32'(validCycles - snapValid), 32'd1);
        checkOutput("A5 frame_err", 32'(errPulses), 32'(expErrs));
        checkOutput("A5 overrun", 32'(overrun), 32'(expOverrun));

        // Two back-to-back frames while the consumer is stalled.
        // The first byte is held, the second is lost and overrun is set.
        rxReady = 1'b0;
        applyStimulus(8'h3C, 1'b1);
        applyStimulus(8'hC3, 1'b1);
        RsRx = 1'b1;
        waitCycles(2 * CPB);
        checkOutput("stall rx_valid", 32'(rxValid), 32'd1);
        checkOutput("stall rx_data", 32'(rxData), 32'h3C);
        checkOutput("stall overrun", 32'(overrun), 32'(expOverrun));
        rxReady = 1'b1;
        waitCycles(1);
        rxReady = 1'b0;
        modelFull = 1'b0;
        expOverrun = 1'b0;
        checkOutput("drain rx_valid", 32'(rxValid), 32'd0);
        checkOutput("drain overrun", 32'(overrun), 32'(expOverrun));
        rxReady = 1'b1;

        // A short low glitch must abort in START without any output.
        snapValid = validCycles;
        RsRx = 1'b0;
        waitCycles(5);
        RsRx = 1'b1;
        checkOutput("glitch busy", 32'(busy), 32'd1);
        waitCycles(30);
        checkOutput("glitch idle", 32'(busy), 32'd0);
        checkOutput("glitch valid", 32'(validCycles - snapValid), 32'd0);
        checkOutput("glitch frame_err", 32'(errPulses), 32'(expErrs));

        // A line held low from reset gives exactly one framing error.
        snapValid = validCycles;
        rst = 1'b1;
        RsRx = 1'b0;
        waitCycles(10);
        rst = 1'b0;
        expErrs++;
        waitCycles(2000);
        checkOutput("break frame_err", 32'(errPulses), 32'(expErrs));
        checkOutput("break busy", 32'(busy), 32'd1);
        checkOutput("break valid", 32'(validCycles - snapValid), 32'd0);
        RsRx = 1'b1;
        waitCycles(3 * CPB);
        checkOutput("break released", 32'(busy), 32'd0);
        applyStimulus(8'h51, 1'b1);
        RsRx = 1'b1;
        waitCycles(2 * CPB);

        // Reset during data bit 4 discards the partial byte.
        driveBit(1'b0);
        for (int i = 0; i < 4; i++) driveBit(1'b0);
        RsRx = 1'b0;
        waitCycles(CPB / 2);
        rst = 1'b1;
        RsRx = 1'b1;
        waitCycles(2);
        rst = 1'b0;
        waitCycles(1);
        checkOutput("abort busy", 32'(busy), 32'd0);
        checkOutput("abort valid", 32'(rxValid), 32'd0);
        waitCycles(3 * CPB);
        applyStimulus(8'h0F, 1'b1);
        RsRx = 1'b1;
        waitCycles(2 * CPB);
        checkOutput("abort overrun", 32'(overrun), 32'd0);
        checkOutput("abort frame_err", 32'(errPulses), 32'(expErrs));

        // Random bytes with random idle gaps, including some bad stop bits.
        for (int n = 0; n < 24; n++) begin
            b = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 4) == 0);
            applyStimulus(b, !bad);
            RsRx = 1'b1;
            gap = bad ? (2 * CPB + $urandom_range(0, CPB)) : $urandom_range(0, 2 * CPB);
            if (gap > 0) waitCycles(gap);
        end
        RsRx = 1'b1;
        waitCycles(3 * CPB);
        checkOutput("random frame_err", 32'(errPulses), 32'(expErrs));
        checkOutput("frame_err width", 32'(errCycles), 32'(errPulses));
        checkOutput("random overrun", 32'(overrun), 32'(expOverrun));
        checkOutput("bytes outstanding", 32'(expQ.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
- UART receiver for the board serial line (RsRx), the receive-direction counterpart to the stopwatch's RsTx transmit path.
- Deserialises 8N1 frames at a fixed baud derived from the 100 MHz clk.
- Presents each byte through a one-entry valid/ready holding register, with framing-error and overrun flags.
- Lets the stopwatch top accept serial commands (start/pause/reset) from the host.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per bit (100 MHz / 115200); legal range 8..65535.
- SYNC_STAGES, 2, flip-flops in the RsRx synchroniser; legal range 2..3.

Ports:
- clk  in  1  system clock, 100 MHz, rising edge.
- rst  in  1  synchronous active-high reset, sampled on clk rising edge.
- RsRx  in  1  asynchronous serial line; idles high.
- rx_data  out  8  received byte, LSB first on the wire; held while rx_valid is high.
- rx_valid  out  1  holding register full.
- rx_ready  in  1  consumer accepts; transfer occurs when rx_valid && rx_ready on a clk edge.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  sticky: a good frame was dropped because the holding register was full.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; all outputs 0; rx_data=8'h00; bit counter and baud counter =0; synchroniser stages preset to 1 (idle level).
- Reset mid-frame aborts the frame with no flags; the partial byte is discarded.
- RsRx passes through SYNC_STAGES flops. All decisions use the synchronised value rxs.
- Baud counter runs 0..CLKS_PER_BIT-1 and restarts on each state entry. "Mid-bit" = count == (CLKS_PER_BIT-1)/2 (integer divide). "Bit end" = count == CLKS_PER_BIT-1.
- States:
  - IDLE: falling level rxs=0 -> START.
  - START: at mid-bit, if rxs=1 (glitch) -> IDLE with no flags; if rxs=0, restart the counter aligned to mid-bit -> DATA, bit index 0.
  - DATA: every CLKS_PER_BIT cycles sample rxs into shift[idx] (LSB first). After idx 7 is sampled -> STOP.
  - STOP: after CLKS_PER_BIT cycles sample rxs.
    - If 1: deliver the byte (below) -> IDLE.
    - If 0: pulse frame_err, discard the byte -> BREAK.
  - BREAK: wait for rxs=1 for one full CLKS_PER_BIT period -> IDLE. A line held low forever never produces a second frame or a second frame_err.
- Delivery, in the cycle after the stop-bit sample:
  - If rx_valid=0, or rx_valid && rx_ready in that same cycle: load rx_data, rx_valid=1.
  - Otherwise keep the old byte, drop the new one, set overrun=1.
- rx_valid clears on the edge where rx_valid && rx_ready, unless a new byte loads in that same edge; load wins and rx_valid stays 1.
- overrun clears on the first accepted handshake after it was set.
- rx_ready is ignored while rx_valid=0.
- Latency: from the RsRx falling edge to rx_valid rising = SYNC_STAGES + (CLKS_PER_BIT-1)/2 + 9*CLKS_PER_BIT + 2 cycles, ±1 cycle of synchroniser alignment.
- A new start bit is accepted in the cycle immediately after STOP returns to IDLE, so back-to-back frames need no extra idle time.
- Counter widths: baud counter $clog2(CLKS_PER_BIT); bit index 3 bits.

Decomposition:
- Package stopwatch_pkg holds:
  - CLK_HZ=100_000_000 and BAUD=115200 constants.
  - A derived CLKS_PER_BIT function.
  - The rx state enum: IDLE, START, DATA, STOP, BREAK.
- One natural sub-module: sync_bit, a parameterised N-flop synchroniser with reset value 1. The stopwatch top reuses it for btnS and btnR.
- The FSM, baud counter and holding register stay in uart_rx_byte.

Test Plan (bench overrides CLKS_PER_BIT=16, clk period 10 ns):
- Assert rst 10 cycles with RsRx=1, then release -> all outputs 0, busy=0; idle line for 500 cycles gives no activity.
- Send frame 8'hA5 with rx_ready=1 -> exactly one rx_valid cycle with rx_data=8'hA5, frame_err=0, overrun=0.
- Send 8'h3C then 8'hC3 back-to-back (no idle gap) with rx_ready=0 -> rx_valid=1, rx_data=8'h3C, overrun=1. Then pulse rx_ready -> rx_valid=0, overrun=0.
- Drive a 5-cycle low glitch on RsRx -> START aborts, rx_valid and frame_err stay 0, busy returns to 0.
- Hold RsRx=0 from reset release for 2000 cycles -> exactly one frame_err pulse, no rx_valid. Release the line, then send 8'h51 -> received correctly.
- Assert rst during bit 4 of a frame, then send 8'h0F -> no output from the aborted frame; 8'h0F delivered with no flags.
